// File: rtl/l1dcache_control.sv
// L1 data cache controller: CHECK / WRITEBACK / FETCH sequencing for a
// write-back, write-allocate cache with a 256-bit line memory interface.
// All control outputs are a combinational decode of the current state and inputs.
// Optional performance counters are enabled by defining L1DCACHE_PERF_CNT_EN;
// without it the counter ports read as zero and no counter flops exist.
module l1dcache_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit,
    input  logic        dirty,
    input  logic        pmem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic        pmem_addr_sel,
    output logic        load_lru,
    output logic        load_tag,
    output logic        load_data,
    output logic        load_valid,
    output logic        data_in_sel,
    output logic        set_dirty,
    output logic        clr_dirty,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
);

    typedef enum logic [1:0] {StCheck, StWriteback, StFetch} state_e;

    state_e state_q, state_d;
    logic   req;

    // A simultaneous read and write is handled as a write.
    assign req = mem_read | mem_write;

    // Next-state and output decode; everything is forced low while in reset.
    always_comb begin
        state_d       = state_q;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        load_lru      = 1'b0;
        load_tag      = 1'b0;
        load_data     = 1'b0;
        load_valid    = 1'b0;
        data_in_sel   = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StCheck: begin
                    // pmem_resp is deliberately ignored here.
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        if (mem_write) begin
                            load_data   = 1'b1;
                            data_in_sel = 1'b1;
                            set_dirty   = 1'b1;
                        end
                    end else if (req) begin
                        state_d = dirty ? StWriteback : StFetch;
                    end
                end
                StWriteback: begin
                    // Evict the dirty LRU line to its own address.
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    // Fill completes even if the CPU dropped its request.
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data  = 1'b1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                        clr_dirty  = 1'b1;
                        state_d    = StCheck;
                    end
                end
                default: state_d = StCheck;
            endcase
        end
    end

    // State register with synchronous reset back to CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCheck;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef L1DCACHE_PERF_CNT_EN
    logic        hit_evt, miss_evt, wb_evt;
    logic [31:0] hit_count_q, miss_count_q, wb_count_q;

    assign hit_evt  = (state_q == StCheck) && req && hit;
    assign miss_evt = (state_q == StCheck) && req && !hit;
    assign wb_evt   = (state_q == StWriteback) && pmem_resp;

    // Saturating event counters; reset wins over any increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            if (hit_evt && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_evt && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
            if (wb_evt && (wb_count_q != 32'hFFFF_FFFF)) begin
                wb_count_q <= wb_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_l1dcache_control.sv
// Directed self-checking bench for l1dcache_control.
// Inputs change 1 time unit after the rising edge; outputs are checked
// at the falling edge.
module tb_l1dcache_control;

`ifdef L1DCACHE_PERF_CNT_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    // Control bundle: {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_lru,
    //                  load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty}
    localparam logic [10:0] CNone  = 11'b000_0000_0000;
    localparam logic [10:0] CRhit  = 11'b100_0100_0000;
    localparam logic [10:0] CWhit  = 11'b100_0101_0110;
    localparam logic [10:0] CFetch = 11'b010_0000_0000;
    localparam logic [10:0] CFill  = 11'b010_0011_1001;
    localparam logic [10:0] CWb    = 11'b001_1000_0000;

    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write, hit, dirty, pmem_resp;
    logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_lru, load_tag;
    logic        load_data, load_valid, data_in_sel, set_dirty, clr_dirty;
    logic [31:0] hit_count, miss_count, wb_count;
    logic [10:0] ctl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign ctl = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, load_lru,
                  load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty};

    l1dcache_control dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_resp     (mem_resp),
        .hit          (hit),
        .dirty        (dirty),
        .pmem_resp    (pmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_addr_sel(pmem_addr_sel),
        .load_lru     (load_lru),
        .load_tag     (load_tag),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .data_in_sel  (data_in_sel),
        .set_dirty    (set_dirty),
        .clr_dirty    (clr_dirty),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .wb_count     (wb_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait to the falling edge and compare the control bundle.
    task automatic chk_ctl(input string tag, input logic [10:0] exp);
        @(negedge clk);
        chk(tag, {21'd0, ctl}, {21'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input int h, input int m, input int w);
        chk({tag, "_hit"},  hit_count,  Perf ? 32'(h) : 32'd0);
        chk({tag, "_miss"}, miss_count, Perf ? 32'(m) : 32'd0);
        chk({tag, "_wb"},   wb_count,   Perf ? 32'(w) : 32'd0);
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic h, input logic d,
                          input logic pr);
        mem_read  = rd;
        mem_write = wr;
        hit       = h;
        dirty     = d;
        pmem_resp = pr;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        // Outputs forced low in reset even with a hitting request.
        chk_ctl("rst_outputs_low", CNone);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_ctl("rst_outputs_low_2", CNone);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctl("idle", CNone);
        chk_cnt("reset", 0, 0, 0);
        tick();

        // Read hit.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("read_hit", CRhit);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("after_rhit", 1, 0, 0);

        // Write hit, then simultaneous read+write treated as write.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_ctl("write_hit", CWhit);
        tick();
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_ctl("rw_as_write", CWhit);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("after_whit", 3, 0, 0);

        // Clean miss, memory responds on 5th FETCH cycle.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctl("clean_miss_check", CNone);
        tick();
        for (int i = 1; i <= 4; i++) begin
            chk_ctl($sformatf("clean_fetch_%0d", i), CFetch);
            tick();
        end
        pmem_resp = 1'b1;
        chk_ctl("clean_fill", CFill);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("clean_post_hit", CRhit);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("after_clean", 4, 1, 0);

        // Dirty miss: 3-cycle writeback, 4-cycle fetch.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_ctl("dirty_miss_check", CNone);
        tick();
        for (int i = 1; i <= 3; i++) begin
            pmem_resp = (i == 3);
            chk_ctl($sformatf("dirty_wb_%0d", i), CWb);
            tick();
        end
        pmem_resp = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk_ctl($sformatf("dirty_fetch_%0d", i), CFetch);
            tick();
        end
        pmem_resp = 1'b1;
        chk_ctl("dirty_fill", CFill);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("dirty_post_hit", CRhit);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("after_dirty", 5, 2, 1);

        // Stray pmem_resp in CHECK does nothing.
        pmem_resp = 1'b1;
        chk_ctl("stray_resp", CNone);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("still_check", CRhit);
        tick();

        // Request dropped during FETCH: fill still completes, no mem_resp.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctl("drop_fetch", CFetch);
        tick();
        pmem_resp = 1'b1;
        chk_ctl("drop_fill", CFill);
        tick();
        pmem_resp = 1'b0;
        chk_ctl("drop_back_idle", CNone);
        chk_cnt("after_drop", 6, 3, 1);

        // Reset in FETCH cycle 2.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_ctl("rst_fetch_1", CFetch);
        tick();
        rst = 1'b1;
        chk_ctl("rst_fetch_2", CNone);
        tick();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctl("rst_after", CNone);
        chk_cnt("after_rst", 0, 0, 0);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctl("rst_in_check", CRhit);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("final", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l1dcache_control.md
L1DCACHE_CONTROL -- requirements
Module: l1dcache_control

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset. One clock only.
REQ-002 SHALL have ports: mem_read input 1, mem_write input 1, CPU request strobes; mem_resp output 1, CPU completion pulse.
REQ-003 SHALL have ports: hit input 1, dirty input 1, datapath status for the addressed set (dirty is for the LRU way).
REQ-004 SHALL have ports: pmem_resp input 1; pmem_read output 1; pmem_write output 1, 256-bit line memory handshake.
REQ-005 SHALL have ports: pmem_addr_sel, load_lru, load_tag, load_data, load_valid, data_in_sel, set_dirty, clr_dirty, all output 1, datapath controls.
REQ-006 SHALL have ports: hit_count, miss_count, wb_count, all output 32, performance counters.

Function
REQ-007 SHALL implement FSM states CHECK, WRITEBACK, FETCH; every output SHALL be a combinational decode of state and inputs.
REQ-008 CHECK, no request: all outputs 0; stay in CHECK.
REQ-009 CHECK, request and hit=1: mem_resp=1 and load_lru=1 in the same cycle (0-cycle hit latency); stay in CHECK.
REQ-010 CHECK, mem_write and hit=1: additionally load_data=1, data_in_sel=1, set_dirty=1 in that cycle.
REQ-011 CHECK, request and hit=0: mem_resp=0; next state WRITEBACK if dirty=1, else FETCH.
REQ-012 WRITEBACK: pmem_write=1, pmem_addr_sel=1 (evicted-line address); hold until pmem_resp=1, then go to FETCH.
REQ-013 FETCH: pmem_read=1, pmem_addr_sel=0; on pmem_resp=1 in the same cycle assert load_data=1, data_in_sel=0, load_tag=1, load_valid=1, clr_dirty=1; then go to CHECK.
REQ-014 After a fill, the request SHALL be serviced as a hit in CHECK, giving miss latency = memory latency(s) + 1 cycle.
REQ-015 mem_read and mem_write both 1: treat as write.
REQ-016 Request deasserted during WRITEBACK/FETCH: the miss sequence SHALL still complete; no mem_resp is issued for it.
REQ-017 pmem_read and pmem_write SHALL never be 1 in the same cycle; mem_resp SHALL never be 1 outside CHECK.
REQ-018 pmem_resp while in CHECK SHALL be ignored.
REQ-019 A request held high after mem_resp SHALL be treated as a new request in the next cycle.

Reset
REQ-020 rst=1 at a clock edge SHALL force state to CHECK and all counters to 0, including mid-WRITEBACK or mid-FETCH.
REQ-021 While rst=1, all control outputs SHALL be 0 regardless of inputs.
REQ-022 Reset SHALL take priority over all other transitions and counter increments.

Configuration
REQ-023 Macro L1DCACHE_PERF_CNT_EN defined: counters SHALL be active.
REQ-024 Counter rules: hit_count increments on each CHECK cycle with request and hit=1 (including post-fill hits); miss_count increments on each CHECK-to-WRITEBACK/FETCH transition; wb_count increments on each WRITEBACK exit.
REQ-025 Counters SHALL saturate at 0xFFFFFFFF.
REQ-026 Macro not defined: the three counter ports SHALL remain present, be tied to 0, and no counter flops SHALL be synthesized; FSM behaviour SHALL be identical.

Verification
REQ-027 Read hit: mem_read=1, hit=1 -> mem_resp=1 and load_lru=1 in the same cycle; hit_count goes 0 to 1.
REQ-028 Write hit: mem_write=1, hit=1 -> load_data=1, data_in_sel=1, set_dirty=1, mem_resp=1 for one cycle; no pmem activity.
REQ-029 Clean miss: mem_read=1, hit=0, dirty=0, pmem_resp after 5 cycles -> pmem_read high for 5 cycles, fill strobes on the resp cycle, then hit=1 gives mem_resp; miss_count=1, wb_count=0.
REQ-030 Dirty miss: hit=0, dirty=1, pmem_resp after 3 cycles for the write and 4 cycles for the read -> pmem_write high for 3 cycles with pmem_addr_sel=1, then pmem_read high for 4 cycles, then mem_resp; wb_count=1.
REQ-031 Reset mid-FETCH: rst=1 in FETCH cycle 2 -> next cycle state is CHECK, pmem_read=0, all counters=0.
REQ-032 Macro undefined, run REQ-029 -> hit_count, miss_count and wb_count all read 0; all other waveforms are identical.
